// File: rtl/rpn_pkg.sv
// Shared types for the RPN evaluation controller: FSM states, opcodes and
// error codes reported on err_code.
package rpn_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PUSH_V = 3'd1,
    POP_B  = 3'd2,
    POP_A  = 3'd3,
    PUSH_R = 3'd4,
    ERR    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } opcode_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;

endpackage

// File: rtl/rpn_alu.sv
// Combinational operator unit: y = a op b, truncated to WORD_BITS.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WORD_BITS = 4
) (
  input  logic [WORD_BITS-1:0] a,
  input  logic [WORD_BITS-1:0] b,
  input  logic [1:0]           op,
  output logic [WORD_BITS-1:0] y
);

  // operator select; results wrap modulo 2^WORD_BITS
  always_comb begin
    y = '0;
    case (opcode_t'(op))
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      OP_AND:  y = a & b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_ctrl.sv
// Reverse-Polish evaluation controller driving a stack's push/pop port.
// Moore FSM: operands are pushed, operators pop B then A and push A op B.
module rpn_ctrl
  import rpn_pkg::*;
#(
  parameter int WORD_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tok_valid,
  output logic                 tok_ready,
  input  logic                 tok_is_op,
  input  logic [WORD_BITS-1:0] tok_data,
  output logic                 push,
  output logic                 pop,
  output logic [WORD_BITS-1:0] push_data,
  input  logic [WORD_BITS-1:0] pop_data,
  input  logic                 empty,
  input  logic                 full,
  output logic [WORD_BITS-1:0] result,
  output logic                 result_valid,
  output logic                 err,
  output logic [1:0]           err_code,
  input  logic                 err_clr
);

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_tok_is_op;
  logic [WORD_BITS-1:0]   r_tok_data;
  logic [WORD_BITS-1:0]   r_a;
  logic [WORD_BITS-1:0]   r_b;
  logic [WORD_BITS-1:0]   r_result;
  logic                   r_result_valid;
  logic [1:0]             r_err_code;
  logic [WORD_BITS-1:0]   w_alu_y;

  rpn_alu #(.WORD_BITS(WORD_BITS)) u_alu (
    .a  (r_a),
    .b  (r_b),
    .op (r_tok_data[1:0]),
    .y  (w_alu_y)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (tok_valid) begin
          w_next = tok_is_op ? POP_B : PUSH_V;
        end else begin
          w_next = IDLE;
        end
      end
      PUSH_V:  w_next = full  ? ERR : IDLE;
      POP_B:   w_next = empty ? ERR : POP_A;
      POP_A:   w_next = empty ? ERR : PUSH_R;
      PUSH_R:  w_next = IDLE;
      ERR: begin
        if (err_clr) begin
          w_next = IDLE;
        end else begin
          w_next = ERR;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // token latch, operand capture, result and sticky error code
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tok_is_op    <= 1'b0;
      r_tok_data     <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_err_code     <= ERR_NONE;
    end else begin
      r_result_valid <= (r_state == PUSH_R);
      if (r_state == IDLE && tok_valid) begin
        r_tok_is_op <= tok_is_op;
        r_tok_data  <= tok_data;
      end
      if (r_state == POP_B && !empty) begin
        r_b <= pop_data;
      end
      if (r_state == POP_A && !empty) begin
        r_a <= pop_data;
      end
      if (r_state == PUSH_R) begin
        r_result <= w_alu_y;
      end
      if (r_state == PUSH_V && full) begin
        r_err_code <= ERR_OVF;
      end else if ((r_state == POP_B || r_state == POP_A) && empty) begin
        r_err_code <= ERR_UNF;
      end else if (r_state == ERR && err_clr) begin
        r_err_code <= ERR_NONE;
      end
    end
  end

  // Moore strobes; PUSH_V only pushes the latched operand (r_tok_is_op=0),
  // PUSH_R only follows an operator (r_tok_is_op=1)
  always_comb begin
    tok_ready = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    err       = 1'b0;
    case (r_state)
      IDLE:    tok_ready = 1'b1;
      PUSH_V:  push = !full;
      POP_B:   pop  = !empty;
      POP_A:   pop  = !empty;
      PUSH_R:  push = 1'b1;
      ERR:     err  = 1'b1;
      default: tok_ready = 1'b0;
    endcase
    if (push) begin
      push_data = r_tok_is_op ? w_alu_y : r_tok_data;
    end else begin
      push_data = '0;
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign err_code     = r_err_code;

endmodule

// File: tb/tb_rpn_ctrl.sv
// Bench for rpn_ctrl with a depth-4 stack model; tokens are checked against
// a queue-based RPN reference model.
module tb_rpn_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tok_valid = 1'b0;
  logic       tok_ready;
  logic       tok_is_op = 1'b0;
  logic [3:0] tok_data = 4'd0;
  logic       push, pop;
  logic [3:0] push_data;
  logic [3:0] pop_data;
  logic       empty, full;
  logic [3:0] result;
  logic       result_valid;
  logic       err;
  logic [1:0] err_code;
  logic       err_clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // stack environment (depth 4)
  logic [3:0] stk_mem [4];
  logic [2:0] stk_cnt = 3'd0;
  logic       stk_flush = 1'b0;

  // reference model state
  logic [3:0] ref_q [$];
  logic [3:0] ref_result = 4'd0;
  logic       ref_err = 1'b0;
  logic [1:0] ref_code = 2'b00;
  int         ref_rv = 0;
  int         rv_cnt = 0;

  always #5 clk = ~clk;

  rpn_ctrl #(.WORD_BITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_is_op    (tok_is_op),
    .tok_data     (tok_data),
    .push         (push),
    .pop          (pop),
    .push_data    (push_data),
    .pop_data     (pop_data),
    .empty        (empty),
    .full         (full),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .err_code     (err_code),
    .err_clr      (err_clr)
  );

  always @(posedge clk) begin
    if (stk_flush) stk_cnt <= 3'd0;
    else if (push && stk_cnt < 3'd4) begin
      stk_mem[stk_cnt[1:0]] <= push_data;
      stk_cnt <= stk_cnt + 3'd1;
    end else if (pop && stk_cnt > 3'd0) stk_cnt <= stk_cnt - 3'd1;
  end

  assign empty    = (stk_cnt == 3'd0);
  assign full     = (stk_cnt == 3'd4);
  assign pop_data = empty ? 4'd0 : stk_mem[stk_cnt[1:0] - 2'd1];

  always @(negedge clk) begin
    if (result_valid) rv_cnt++;
    if (push || pop) begin
      vectors++;
      if (push && pop) begin
        miscompares++;
        $display("FAIL push_pop_excl: push=%0b pop=%0b, required not both", push, pop);
      end
    end
  end

  task automatic ref_apply(input logic op, input logic [3:0] d);
    logic [3:0] a, b, y;
    if (!op) begin
      if (ref_q.size() == 4) begin ref_err = 1'b1; ref_code = 2'b01; end
      else ref_q.push_back(d);
    end else if (ref_q.size() == 0) begin
      ref_err = 1'b1; ref_code = 2'b10;
    end else begin
      b = ref_q.pop_back();
      if (ref_q.size() == 0) begin
        ref_err = 1'b1; ref_code = 2'b10;
      end else begin
        a = ref_q.pop_back();
        case (d[1:0])
          2'd0: y = a + b;
          2'd1: y = a - b;
          2'd2: y = a * b;
          default: y = a & b;
        endcase
        ref_q.push_back(y);
        ref_result = y;
        ref_rv++;
      end
    end
  endtask

  task automatic flush();
    @(negedge clk); stk_flush = 1'b1;
    @(posedge clk); #1 stk_flush = 1'b0;
    ref_q.delete();
  endtask

  task automatic send_tok(input logic op, input logic [3:0] d);
    int n = 0;
    @(negedge clk);
    tok_valid = 1'b1; tok_is_op = op; tok_data = d;
    while (!tok_ready && n < 20) begin @(negedge clk); n++; end
    if (!tok_ready) begin
      vectors++; miscompares++;
      $display("FAIL tok_accept: tok_ready=%0b after %0d cycles, required 1", tok_ready, n);
      tok_valid = 1'b0;
    end else begin
      @(posedge clk); #1 tok_valid = 1'b0;
    end
  endtask

  task automatic settle();
    int n = 0;
    @(negedge clk);
    while (!(tok_ready || err) && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (!(tok_ready || err)) begin
      miscompares++;
      $display("FAIL settle: no IDLE/ERR after %0d cycles", n);
    end
    @(negedge clk);
  endtask

  task automatic send_and_check(input logic op, input logic [3:0] d);
    ref_apply(op, d);
    send_tok(op, d);
    settle();
    vectors += 6;
    if (err !== ref_err) begin miscompares++; $display("FAIL err: got %0b, required %0b", err, ref_err); end
    if (err_code !== ref_code) begin miscompares++; $display("FAIL err_code: got %0d, required %0d", err_code, ref_code); end
    if (result !== ref_result) begin miscompares++; $display("FAIL result: got %0d, required %0d", result, ref_result); end
    if (rv_cnt !== ref_rv) begin miscompares++; $display("FAIL result_valid_count: got %0d, required %0d", rv_cnt, ref_rv); end
    if (tok_ready !== !ref_err) begin miscompares++; $display("FAIL tok_ready: got %0b, required %0b", tok_ready, !ref_err); end
    if (int'(stk_cnt) != ref_q.size()) begin
      miscompares++; $display("FAIL stack_depth: got %0d, required %0d", stk_cnt, ref_q.size());
    end else begin
      for (int i = 0; i < ref_q.size(); i++) begin
        if (stk_mem[i] !== ref_q[i]) begin
          miscompares++; $display("FAIL stack_entry[%0d]: got %0d, required %0d", i, stk_mem[i], ref_q[i]);
        end
      end
    end
  endtask

  task automatic clear_err();
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    ref_err = 1'b0; ref_code = 2'b00;
    @(negedge clk);
    vectors += 3;
    if (err !== 1'b0) begin miscompares++; $display("FAIL clr_err: got %0b, required 0", err); end
    if (err_code !== 2'b00) begin miscompares++; $display("FAIL clr_code: got %0d, required 0", err_code); end
    if (tok_ready !== 1'b1) begin miscompares++; $display("FAIL clr_ready: got %0b, required 1", tok_ready); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors += 6;
    if (tok_ready !== 1'b1 || push !== 1'b0 || pop !== 1'b0) begin
      miscompares++; $display("FAIL reset_strobes: ready=%0b push=%0b pop=%0b, required 1/0/0", tok_ready, push, pop);
    end
    if (push_data !== 4'd0) begin miscompares++; $display("FAIL reset_push_data: got %0d, required 0", push_data); end
    if (result !== 4'd0) begin miscompares++; $display("FAIL reset_result: got %0d, required 0", result); end
    if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rv: got %0b, required 0", result_valid); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %0b, required 0", err); end
    if (err_code !== 2'b00) begin miscompares++; $display("FAIL reset_code: got %0d, required 0", err_code); end
    rst = 1'b1;
    flush();
    send_and_check(1'b0, 4'd3);
    send_and_check(1'b0, 4'd5);
    // ADD, then reset while in POP_A
    @(negedge clk); tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 4'd0;
    @(posedge clk); #1 tok_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (pop !== 1'b1) begin miscompares++; $display("FAIL pop_a_strobe: got %0b, required 1", pop); end
    rst = 1'b0; #1;
    vectors += 4;
    if (push !== 1'b0 || pop !== 1'b0) begin miscompares++; $display("FAIL midop_strobes: push=%0b pop=%0b, required 0/0", push, pop); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL midop_err: got %0b, required 0", err); end
    if (result !== 4'd0) begin miscompares++; $display("FAIL midop_result: got %0d, required 0", result); end
    if (tok_ready !== 1'b1) begin miscompares++; $display("FAIL midop_ready: got %0b, required 1", tok_ready); end
    @(negedge clk); rst = 1'b1;
    vectors++;
    if (stk_cnt !== 3'd1 || stk_mem[0] !== 4'd3) begin
      miscompares++; $display("FAIL midop_stack: depth=%0d top=%0d, required 1/3", stk_cnt, stk_mem[0]);
    end
    flush();
  endtask

  task automatic test_ops();
    logic [3:0] av [4] = '{4'd3, 4'd9, 4'd2, 4'd7};
    logic [3:0] bv [4] = '{4'd5, 4'd2, 4'd5, 4'd3};
    logic [3:0] ov [4] = '{4'd0, 4'd1, 4'd1, 4'd2};
    logic [3:0] ev [4] = '{4'd8, 4'd7, 4'd13, 4'd5};
    for (int k = 0; k < 4; k++) begin
      flush();
      send_and_check(1'b0, av[k]);
      send_and_check(1'b0, bv[k]);
      send_and_check(1'b1, ov[k]);
      vectors++;
      if (result !== ev[k]) begin miscompares++; $display("FAIL op_case%0d: got %0d, required %0d", k, result, ev[k]); end
    end
  endtask

  task automatic test_overflow();
    flush();
    for (int k = 1; k <= 4; k++) send_and_check(1'b0, 4'(k));
    vectors++;
    if (full !== 1'b1) begin miscompares++; $display("FAIL full_flag: got %0b, required 1", full); end
    send_and_check(1'b0, 4'd6);
    vectors++;
    if (err_code !== 2'b01) begin miscompares++; $display("FAIL ovf_code: got %0d, required 1", err_code); end
    clear_err();
    vectors++;
    if (pop_data !== 4'd4) begin miscompares++; $display("FAIL ovf_top: got %0d, required 4", pop_data); end
  endtask

  task automatic test_underflow();
    logic [3:0] res_before;
    flush();
    res_before = result;
    send_and_check(1'b0, 4'd1);
    send_and_check(1'b1, 4'd0);
    vectors += 3;
    if (err_code !== 2'b10) begin miscompares++; $display("FAIL unf_code: got %0d, required 2", err_code); end
    if (empty !== 1'b1) begin miscompares++; $display("FAIL unf_empty: got %0b, required 1", empty); end
    if (result !== res_before) begin miscompares++; $display("FAIL unf_result: got %0d, required %0d", result, res_before); end
    clear_err();
  endtask

  task automatic test_back_to_back();
    logic       ops [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] ds  [6] = '{4'd4, 4'd5, 4'd0, 4'd2, 4'd2, 4'd3};
    int tcyc [6];
    int i = 0;
    int cyc = 0;
    logic xfer;
    flush();
    for (int k = 0; k < 6; k++) ref_apply(ops[k], ds[k]);
    tok_valid = 1'b1;
    while (i < 6 && cyc < 200) begin
      @(negedge clk);
      tok_is_op = ops[i]; tok_data = ds[i];
      xfer = tok_ready;
      if (xfer) tcyc[i] = cyc;
      @(posedge clk); #1;
      if (xfer) i++;
      cyc++;
    end
    tok_valid = 1'b0;
    vectors++;
    if (i != 6) begin miscompares++; $display("FAIL b2b_count: got %0d transfers, required 6", i); end
    for (int k = 1; k < i; k++) begin
      vectors++;
      if (tcyc[k] - tcyc[k-1] != (ops[k-1] ? 4 : 2)) begin
        miscompares++;
        $display("FAIL b2b_gap%0d: got %0d, required %0d", k, tcyc[k] - tcyc[k-1], ops[k-1] ? 4 : 2);
      end
    end
    settle();
    vectors += 3;
    if (result !== 4'd2) begin miscompares++; $display("FAIL b2b_result: got %0d, required 2", result); end
    if (stk_cnt !== 3'd2) begin miscompares++; $display("FAIL b2b_depth: got %0d, required 2", stk_cnt); end
    if (stk_mem[0] !== 4'd2 || stk_mem[1] !== 4'd3) begin
      miscompares++; $display("FAIL b2b_stack: got %0d,%0d, required 2,3", stk_mem[0], stk_mem[1]);
    end
  endtask

  task automatic test_random();
    logic       op;
    logic [3:0] d;
    flush();
    for (int k = 0; k < 80; k++) begin
      op = ($urandom_range(0, 9) < 4);
      d  = 4'($urandom_range(0, 15));
      send_and_check(op, d);
      if (ref_err) clear_err();
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
